// File: rtl/ucsbece154b_icache_pkg.sv
// rtl/ucsbece154b_icache_pkg.sv - refill FSM encoding and address-split width helpers for the icache
package ucsbece154b_icache_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_REFILL = 2'd2
   } state_t;

   function automatic int word_bits(input int words_per_block);
      return $clog2(words_per_block);
   endfunction

   function automatic int index_bits(input int num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int tag_bits(input int addr_width, input int num_sets, input int words_per_block);
      return addr_width - 2 - $clog2(words_per_block) - $clog2(num_sets);
   endfunction

endpackage

// File: rtl/ucsbece154b_icache_array.sv
// rtl/ucsbece154b_icache_array.sv - valid/tag/data storage, one combinational read port, one word write port
module ucsbece154b_icache_array #(
   parameter int NUM_SETS        = 32,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int IDX_W           = 5,
   parameter int WRD_W           = 2,
   parameter int TAG_W           = 25
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] i_rd_index,
   input  logic [WRD_W-1:0] i_rd_word,
   output logic             o_rd_valid,
   output logic [TAG_W-1:0] o_rd_tag,
   output logic [31:0]      o_rd_data,
   input  logic             i_wr_data_en,
   input  logic [IDX_W-1:0] i_wr_index,
   input  logic [WRD_W-1:0] i_wr_word,
   input  logic [31:0]      i_wr_data,
   input  logic             i_wr_tag_en,
   input  logic [TAG_W-1:0] i_wr_tag
);

   logic [NUM_SETS-1:0] r_valid;
   logic [TAG_W-1:0]    r_tag  [NUM_SETS];
   logic [31:0]         r_data [NUM_SETS][WORDS_PER_BLOCK];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
      end else if (i_wr_tag_en) begin
         r_valid[i_wr_index] <= 1'b1;
      end
   end

   // Tag and data contents are meaningless until valid is set, so they carry no reset.
   always_ff @(posedge clk) begin
      if (i_wr_data_en) begin
         r_data[i_wr_index][i_wr_word] <= i_wr_data;
      end
      if (i_wr_tag_en) begin
         r_tag[i_wr_index] <= i_wr_tag;
      end
   end

   assign o_rd_valid = r_valid[i_rd_index];
   assign o_rd_tag   = r_tag[i_rd_index];
   assign o_rd_data  = r_data[i_rd_index][i_rd_word];

endmodule

// File: rtl/ucsbece154b_icache.sv
// rtl/ucsbece154b_icache.sv - direct-mapped read-only instruction cache with burst refill
module ucsbece154b_icache
   import ucsbece154b_icache_pkg::*;
#(
   parameter int NUM_SETS        = 32,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int ADDR_WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ReadEnable_i,
   input  logic [ADDR_WIDTH-1:0] ReadAddress_i,
   output logic [31:0]           Instruction_o,
   output logic                  Ready_o,
   output logic                  MemReadRequest_o,
   output logic [ADDR_WIDTH-1:0] MemReadAddress_o,
   input  logic [31:0]           MemDataIn_i,
   input  logic                  MemDataReady_i
);

   localparam int W = word_bits(WORDS_PER_BLOCK);
   localparam int I = index_bits(NUM_SETS);
   localparam int T = tag_bits(ADDR_WIDTH, NUM_SETS, WORDS_PER_BLOCK);
   localparam int B = I + T;
   localparam logic [W-1:0] LAST_WORD = W'(WORDS_PER_BLOCK - 1);

   state_t         r_state, w_next;
   logic [W-1:0]   r_count;
   logic [B-1:0]   r_block;

   logic [W-1:0]   w_word;
   logic [I-1:0]   w_index;
   logic [T-1:0]   w_tag;
   logic           w_unused_offset;
   logic           w_valid;
   logic [T-1:0]   w_rd_tag;
   logic [31:0]    w_rd_data;
   logic           w_hit;
   logic           w_miss;
   logic           w_data_en;
   logic           w_last;

   assign w_word          = ReadAddress_i[W+1:2];
   assign w_index         = ReadAddress_i[W+I+1:W+2];
   assign w_tag           = ReadAddress_i[ADDR_WIDTH-1:W+I+2];
   assign w_unused_offset = ^ReadAddress_i[1:0];

   ucsbece154b_icache_array #(
      .NUM_SETS        (NUM_SETS),
      .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
      .IDX_W           (I),
      .WRD_W           (W),
      .TAG_W           (T)
   ) u_array (
      .clk          (clk),
      .reset        (reset),
      .i_rd_index   (w_index),
      .i_rd_word    (w_word),
      .o_rd_valid   (w_valid),
      .o_rd_tag     (w_rd_tag),
      .o_rd_data    (w_rd_data),
      .i_wr_data_en (w_data_en),
      .i_wr_index   (r_block[I-1:0]),
      .i_wr_word    (r_count),
      .i_wr_data    (MemDataIn_i),
      .i_wr_tag_en  (w_last),
      .i_wr_tag     (r_block[B-1:I])
   );

   assign w_hit     = ReadEnable_i & w_valid & (w_rd_tag == w_tag) & (r_state == S_IDLE);
   assign w_miss    = ReadEnable_i & ~w_hit & (r_state == S_IDLE);
   assign w_data_en = (r_state == S_REFILL) & MemDataReady_i;
   assign w_last    = w_data_en & (r_count == LAST_WORD);

   assign MemReadAddress_o = {r_block, {(W+2){1'b0}}};

   always_comb begin
      w_next           = r_state;
      Ready_o          = 1'b0;
      MemReadRequest_o = 1'b0;
      Instruction_o    = 32'd0;
      case (r_state)
         S_IDLE: begin
            Ready_o = ~ReadEnable_i | w_hit;
            if (w_hit) begin
               Instruction_o = w_rd_data;
            end
            if (w_miss) begin
               w_next = S_REQ;
            end
         end
         S_REQ: begin
            MemReadRequest_o = 1'b1;
            w_next           = S_REFILL;
         end
         S_REFILL: begin
            if (w_last) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // The refill target is captured once on the miss; later address changes cannot redirect it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
         r_block <= '0;
      end else begin
         if (w_miss) begin
            r_block <= ReadAddress_i[ADDR_WIDTH-1:W+2];
         end
         if (w_data_en) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// tb/tb_ucsbece154b_icache.sv - directed and randomized bench against a line-level cache model
module tb_ucsbece154b_icache;

   localparam int NS  = 32;
   localparam int WPB = 4;
   localparam int BLK = 4 * WPB;

   logic        clk;
   logic        reset;
   logic        ReadEnable_i;
   logic [31:0] ReadAddress_i;
   logic [31:0] Instruction_o;
   logic        Ready_o;
   logic        MemReadRequest_o;
   logic [31:0] MemReadAddress_o;
   logic [31:0] MemDataIn_i;
   logic        MemDataReady_i;

   ucsbece154b_icache #(
      .NUM_SETS        (NS),
      .WORDS_PER_BLOCK (WPB),
      .ADDR_WIDTH      (32)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .ReadEnable_i     (ReadEnable_i),
      .ReadAddress_i    (ReadAddress_i),
      .Instruction_o    (Instruction_o),
      .Ready_o          (Ready_o),
      .MemReadRequest_o (MemReadRequest_o),
      .MemReadAddress_o (MemReadAddress_o),
      .MemDataIn_i      (MemDataIn_i),
      .MemDataReady_i   (MemDataReady_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp;
   int          n_bad;
   bit          m_valid [NS];
   int unsigned m_tag   [NS];
   logic [31:0] m_data  [NS][WPB];
   logic [31:0] q_fill  [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int s = 0; s < NS; s++) m_valid[s] = 1'b0;
   endtask

   task automatic reset_with_strays();
      reset          = 1'b0;
      ReadEnable_i   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         MemDataReady_i = 1'b1;
         MemDataIn_i    = $urandom;
         ReadAddress_i  = $urandom;
         @(negedge clk);
         check("rst_ready", Ready_o, 1);
         check("rst_req", MemReadRequest_o, 0);
         check("rst_instr", Instruction_o, 0);
         check("rst_memaddr", MemReadAddress_o, 0);
         next_cycle();
      end
      reset = 1'b1;
      model_clear();
      MemDataReady_i = 1'b1;
      MemDataIn_i    = $urandom;
      @(negedge clk);
      check("postrst_ready", Ready_o, 1);
      check("postrst_req", MemReadRequest_o, 0);
      next_cycle();
      MemDataReady_i = 1'b0;
   endtask

   // mode 0: back-to-back data, 1: pulses at 3,5,9,10 after REQ, 2: random gaps and junk
   task automatic fetch(input logic [31:0] addr, input int mode, input int abort_at);
      int          idx;
      int          wrd;
      int unsigned tg;
      bit          hit;
      int          offs [WPB];
      logic [31:0] words [WPB];
      int          k;
      int          c;
      idx = int'((addr / BLK) % NS);
      wrd = int'((addr / 4) % WPB);
      tg  = addr / (BLK * NS);
      hit = m_valid[idx] && (m_tag[idx] == tg);
      ReadEnable_i   = 1'b1;
      ReadAddress_i  = addr;
      MemDataReady_i = 1'b0;
      @(negedge clk);
      check("lookup_ready", Ready_o, {31'd0, hit});
      check("lookup_req", MemReadRequest_o, 0);
      if (hit) check("hit_instr", Instruction_o, m_data[idx][wrd]);
      next_cycle();
      if (hit) return;

      if (mode == 2 && $urandom_range(1) == 1) begin
         MemDataReady_i = 1'b1;
         MemDataIn_i    = $urandom;
      end
      @(negedge clk);
      check("req_pulse", MemReadRequest_o, 1);
      check("req_addr", MemReadAddress_o, addr & ~32'(BLK - 1));
      check("req_ready", Ready_o, 0);
      next_cycle();
      MemDataReady_i = 1'b0;

      for (int i = 0; i < WPB; i++) begin
         if (mode == 0) offs[i] = i + 1;
         else if (mode == 2) offs[i] = ((i == 0) ? 0 : offs[i-1]) + 1 + int'($urandom_range(0, 3));
      end
      if (mode == 1) begin
         offs[0] = 3; offs[1] = 5; offs[2] = 9; offs[3] = 10;
      end

      k = 0;
      c = 1;
      while (k < WPB) begin
         if (k == abort_at) begin
            reset_with_strays();
            return;
         end
         if (c == offs[k]) begin
            MemDataReady_i = 1'b1;
            if (q_fill.size() != 0) words[k] = q_fill.pop_front();
            else words[k] = $urandom;
            MemDataIn_i   = words[k];
            ReadAddress_i = (k == WPB - 1 || mode != 2) ? addr : $urandom;
            k++;
         end else begin
            MemDataReady_i = 1'b0;
            MemDataIn_i    = $urandom;
            if (mode == 2) ReadAddress_i = $urandom;
         end
         @(negedge clk);
         check("refill_ready", Ready_o, 0);
         check("refill_req", MemReadRequest_o, 0);
         next_cycle();
         c++;
      end
      MemDataReady_i = 1'b0;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      for (int i = 0; i < WPB; i++) m_data[idx][i] = words[i];
      @(negedge clk);
      check("resume_ready", Ready_o, 1);
      check("resume_instr", Instruction_o, words[wrd]);
      check("resume_req", MemReadRequest_o, 0);
      next_cycle();
   endtask

   task automatic idle_cycles(input int n);
      ReadEnable_i = 1'b0;
      for (int i = 0; i < n; i++) begin
         ReadAddress_i  = $urandom;
         MemDataReady_i = 1'($urandom_range(1));
         MemDataIn_i    = $urandom;
         @(negedge clk);
         check("idle_ready", Ready_o, 1);
         check("idle_instr", Instruction_o, 0);
         check("idle_req", MemReadRequest_o, 0);
         next_cycle();
      end
      MemDataReady_i = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      int          ab;
      n_cmp          = 0;
      n_bad          = 0;
      reset          = 1'b0;
      ReadEnable_i   = 1'b0;
      ReadAddress_i  = 32'd0;
      MemDataIn_i    = 32'd0;
      MemDataReady_i = 1'b0;
      model_clear();

      @(negedge clk);
      check("reset_ready", Ready_o, 1);
      check("reset_req", MemReadRequest_o, 0);
      check("reset_memaddr", MemReadAddress_o, 0);
      check("reset_instr", Instruction_o, 0);
      next_cycle();
      next_cycle();

      reset = 1'b1;
      q_fill = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      fetch(32'h0000_0010, 0, -1);
      fetch(32'h0000_0014, 0, -1);
      fetch(32'h0000_001C, 0, -1);

      q_fill = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
      fetch(32'h0000_0210, 0, -1);
      fetch(32'h0000_0218, 0, -1);
      fetch(32'h0000_0010, 0, -1);

      fetch(32'h0000_0400, 1, -1);
      for (int i = 1; i < WPB; i++) fetch(32'h0000_0400 + 32'(4 * i), 0, -1);

      fetch(32'h0000_0820, 0, 2);
      fetch(32'h0000_0820, 0, -1);
      fetch(32'h0000_0824, 0, -1);

      idle_cycles(6);
      fetch(32'h0000_0824, 0, -1);
      fetch(32'h0000_082C, 0, -1);

      for (int n = 0; n < 300; n++) begin
         a = 32'($urandom_range(0, 3)) * 32'(BLK * NS) + 32'($urandom_range(0, 7)) * 32'(BLK)
           + 32'($urandom_range(0, WPB - 1)) * 32'd4 + 32'($urandom_range(0, 3));
         ab = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, WPB - 1)) : -1;
         fetch(a, int'($urandom_range(0, 2)), ab);
         if ($urandom_range(0, 9) == 0) idle_cycles(int'($urandom_range(1, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ucsbece154b_icache.md
Name: ucsbece154b_icache

Overview:
Direct-mapped, read-only instruction cache between the pipeline's fetch stage (PCF/InstrF) and a slow, burst-capable instruction memory. A hit returns the instruction in the same cycle. A miss stalls fetch via Ready_o=0, runs a block refill over a request/data-valid handshake, and then resumes. It replaces the zero-latency combinational imem path in the top level.

Parameters:
NUM_SETS, 32, number of cache lines; power of 2, at least 2.
WORDS_PER_BLOCK, 4, 32-bit words per line; power of 2, at least 2.
ADDR_WIDTH, 32, byte-address width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset (reset=0 resets).
ReadEnable_i  in  1  fetch request valid.
ReadAddress_i  in  ADDR_WIDTH  byte address (PCF); bits [1:0] ignored.
Instruction_o  out  32  fetched instruction; valid when Ready_o=1 and ReadEnable_i=1.
Ready_o  out  1  1 = hit or idle; 0 = stall fetch/decode.
MemReadRequest_o  out  1  one-cycle pulse starting a block refill.
MemReadAddress_o  out  ADDR_WIDTH  block-aligned refill address; low log2(WPB)+2 bits are 0.
MemDataIn_i  in  32  refill word.
MemDataReady_i  in  1  MemDataIn_i valid this cycle.

Behaviour:
- Address split, LSB first:
  - byte offset [1:0]
  - word offset: W = log2(WORDS_PER_BLOCK) bits
  - index: I = log2(NUM_SETS) bits
  - tag: remaining ADDR_WIDTH-2-W-I bits
- Storage per set: valid bit, tag, WORDS_PER_BLOCK data words.
- Hit is combinational: ReadEnable_i & valid[index] & (tag[index]==addr tag) & state==IDLE.
- Reset (async, reset=0):
  - all valid bits cleared; state=IDLE; word counter=0
  - MemReadRequest_o=0, MemReadAddress_o=0, Instruction_o=0, Ready_o=1
  - data/tag arrays are not reset
- FSM states:
  - IDLE:
    - ReadEnable_i=0: Ready_o=1, Instruction_o=0.
    - Hit: Ready_o=1; Instruction_o = data[index][word offset] in the same cycle.
    - Miss: Ready_o=0 combinationally. Latch block-aligned address, tag and index. Go to REQ.
  - REQ (exactly one cycle): MemReadRequest_o=1, MemReadAddress_o=latched address, Ready_o=0. Go to REFILL.
  - REFILL: Ready_o=0, MemReadRequest_o=0.
    - Each cycle with MemDataReady_i=1: write MemDataIn_i to data[index][counter]; counter++.
    - Words arrive in order 0..WPB-1; gaps between pulses are allowed.
    - On the cycle the last word arrives: set valid[index]=1, write tag, counter=0, go to IDLE.
  - Back in IDLE, the stalled fetch is re-looked-up and hits: Ready_o=1 on the first IDLE cycle.
- Miss latency, back-to-back data: miss cycle + REQ + WPB data cycles, then hit. With memory first-word latency L cycles after the request, the stall is 1+L+WPB cycles.
- Valid is written only on completion, so a line is never partially valid.
- The core holds ReadAddress_i stable while Ready_o=0. The cache ignores address changes during REQ/REFILL and always completes the latched refill.
- MemDataReady_i in IDLE or REQ is ignored.
- Conflict miss: the old line is overwritten; its valid bit stays 1 and its tag is replaced at completion. Before completion, the old tag and valid remain, so the old line still matches — but lookups are blocked outside IDLE, so this is safe.
- Reset mid-refill: abort immediately. No further writes; the line is left invalid because all valid bits are cleared. Extra MemDataReady_i pulses after reset are ignored.
- Same-cycle reset deassertion and ReadEnable_i: a normal miss.

Decomposition:
- Package ucsbece154b_icache_pkg holds:
  - FSM state encoding: IDLE, REQ, REFILL
  - helper functions for the offset/index/tag widths derived from the parameters
- Sub-module ucsbece154b_icache_array: valid/tag/data storage with one combinational read port and one synchronous word-write port (separate tag/valid write enable). The FSM, address split and hit logic stay in the top.

Test Plan:
1. Cold miss (defaults): reset low 2 cycles then high; read 0x00000010.
   - Expect Ready_o=0.
   - REQ cycle: MemReadRequest_o=1, MemReadAddress_o=0x00000010.
   - Memory returns 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
   - Next cycle: Ready_o=1, Instruction_o=0xA0.
2. Hit after fill: read 0x00000014, then 0x0000001C.
   - Instruction_o=0xA1, then 0xA3; Ready_o=1 in the same cycle; no MemReadRequest_o.
3. Conflict: read 0x00000210 (same index 1, different tag) and refill with 0xB0..B3.
   - Then read 0x00000010: miss again; MemReadAddress_o=0x00000010.
4. Gapped refill: MemDataReady_i pulses on cycles 3,5,9,10 after the request.
   - Ready_o stays 0 until the cycle after the 4th pulse.
   - Words land at offsets 0..3 in order.
5. Reset mid-refill: assert reset after 2 of 4 words. Then read the same address.
   - Expect a miss, a fresh REQ, and correct data from the new refill.
   - Stray MemDataReady_i during reset corrupts nothing.
6. ReadEnable_i=0 with arbitrary address:
   - Ready_o=1, Instruction_o=0, no request.
   - Spurious MemDataReady_i in IDLE is ignored: a subsequent hit returns the original data.
